commit_trace_fifo: RTL and testbench

//  Sits downstream of the riscv core. Captures register-writeback events and data-memory

---
 rtl/commit_trace_fifo_if.sv | 11 +
 rtl/commit_trace_fifo.sv | 95 +++++++++
 tb/tb_commit_trace_fifo.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/commit_trace_fifo_if.sv
// Drain-side stream of the commit trace FIFO: show-ahead head entry with valid/ready.
interface commit_trace_fifo_if #(
    parameter int ENTRY_W = 42
);
    logic               m_valid;
    logic               m_ready;
    logic [ENTRY_W-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/commit_trace_fifo.sv
// Captures core register-writeback and store events into a trace FIFO and drains them
// in order; the core never stalls, so events that do not fit are dropped and counted.
module commit_trace_fifo #(
    parameter int  DEPTH   = 16,
    parameter int  DATA_W  = 32,
    parameter int  ADDR_W  = 9,
    parameter int  CNT_W   = 16,
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int LVL_W   = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trace_en,
    input  logic              reg_write_sig,
    input  logic [4:0]        reg_num,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wr_data,
    commit_trace_fifo_if.master m,
    output logic [LVL_W-1:0]  level,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              overflow,
    input  logic              clr_drops
);

    logic [ENTRY_W-1:0] storage [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   mem_slot;
    logic [LVL_W-1:0]   free;
    logic               reg_ev;
    logic               mem_ev;
    logic               push_reg;
    logic               push_mem;
    logic               pop;
    logic [1:0]         n_push;
    logic [1:0]         n_drop;
    logic [CNT_W:0]     cnt_sum;
    logic [ENTRY_W-1:0] reg_entry;
    logic [ENTRY_W-1:0] mem_entry;

    assign reg_entry = {1'b0, ADDR_W'(reg_num), reg_data};
    assign mem_entry = {1'b1, mem_addr, mem_wr_data};

    assign m.m_valid = (level != '0);
    assign m.m_data  = storage[rd_ptr];

    // Free space ignores this cycle's pop; REG always claims the first free slot.
    always_comb begin
        reg_ev   = trace_en & reg_write_sig & (reg_num != 5'd0);
        mem_ev   = trace_en & mem_wr;
        free     = LVL_W'(DEPTH) - level;
        push_reg = reg_ev & (free != '0);
        push_mem = mem_ev & (reg_ev ? (free >= LVL_W'(2)) : (free != '0));
        n_push   = {1'b0, push_reg} + {1'b0, push_mem};
        n_drop   = ({1'b0, reg_ev} + {1'b0, mem_ev}) - n_push;
        mem_slot = push_reg ? (wr_ptr + PTR_W'(1)) : wr_ptr;
        pop      = m.m_valid & m.m_ready;
        cnt_sum  = {1'b0, drop_cnt} + (CNT_W+1)'(n_drop);
    end

    always_ff @(posedge clk) begin
        if (push_reg) storage[wr_ptr] <= reg_entry;
        if (push_mem) storage[mem_slot] <= mem_entry;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            wr_ptr <= wr_ptr + PTR_W'(n_push);
            level  <= level + LVL_W'(n_push) - LVL_W'(pop);
        end
    end

    // Clearing takes priority over drops arriving in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (clr_drops) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (n_drop != 2'd0) begin
            drop_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Bench for commit_trace_fifo: a queue-based model checked every cycle on two instances
// (16-bit and 4-bit drop counters), plus hand-computed literal expectations.
module tb_commit_trace_fifo;
    localparam int DEPTH   = 16;
    localparam int ENTRY_W = 42;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trace_en = 1'b0;
    logic        reg_write_sig = 1'b0;
    logic [4:0]  reg_num = '0;
    logic [31:0] reg_data = '0;
    logic        mem_wr = 1'b0;
    logic [8:0]  mem_addr = '0;
    logic [31:0] mem_wr_data = '0;
    logic        m_ready = 1'b0;
    logic        clr_drops = 1'b0;

    logic [4:0]  level16, level4;
    logic [15:0] drop16;
    logic [3:0]  drop4;
    logic        ovf16, ovf4;

    commit_trace_fifo_if #(.ENTRY_W(ENTRY_W)) bus16 ();
    commit_trace_fifo_if #(.ENTRY_W(ENTRY_W)) bus4 ();
    assign bus16.m_ready = m_ready;
    assign bus4.m_ready  = m_ready;

    commit_trace_fifo #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(9), .CNT_W(16)) dut16 (
        .clk(clk), .reset(reset), .trace_en(trace_en), .reg_write_sig(reg_write_sig),
        .reg_num(reg_num), .reg_data(reg_data), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .m(bus16), .level(level16), .drop_cnt(drop16),
        .overflow(ovf16), .clr_drops(clr_drops));

    commit_trace_fifo #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(9), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .trace_en(trace_en), .reg_write_sig(reg_write_sig),
        .reg_num(reg_num), .reg_data(reg_data), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .m(bus4), .level(level4), .drop_cnt(drop4),
        .overflow(ovf4), .clr_drops(clr_drops));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    logic [ENTRY_W-1:0] exp_q[$];
    int exp_drop16 = 0;
    int exp_drop4 = 0;
    bit exp_ovf = 1'b0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: trace is a queue of entries; free space is taken before the pop.
    always @(negedge reset) begin
        exp_q.delete();
        exp_drop16 = 0;
        exp_drop4  = 0;
        exp_ovf    = 1'b0;
    end

    always @(posedge clk) begin
        if (reset) begin
            int free;
            int drops;
            bit r_ev;
            bit m_ev;
            r_ev  = trace_en && reg_write_sig && (reg_num != 5'd0);
            m_ev  = trace_en && mem_wr;
            free  = DEPTH - exp_q.size();
            drops = 0;
            if (exp_q.size() != 0 && m_ready) void'(exp_q.pop_front());
            if (r_ev) begin
                if (free >= 1) begin
                    exp_q.push_back({1'b0, 4'b0000, reg_num, reg_data});
                    free--;
                end else drops++;
            end
            if (m_ev) begin
                if (free >= 1) exp_q.push_back({1'b1, mem_addr, mem_wr_data});
                else drops++;
            end
            if (clr_drops) begin
                exp_drop16 = 0;
                exp_drop4  = 0;
                exp_ovf    = 1'b0;
            end else if (drops != 0) begin
                exp_drop16 = (exp_drop16 + drops > 65535) ? 65535 : exp_drop16 + drops;
                exp_drop4  = (exp_drop4 + drops > 15) ? 15 : exp_drop4 + drops;
                exp_ovf    = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check_output("level16", level16, exp_q.size());
            check_output("level4", level4, exp_q.size());
            check_output("valid16", bus16.m_valid, exp_q.size() != 0);
            check_output("valid4", bus4.m_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check_output("data16", bus16.m_data, exp_q[0]);
                check_output("data4", bus4.m_data, exp_q[0]);
            end
            check_output("drop16", drop16, exp_drop16);
            check_output("drop4", drop4, exp_drop4);
            check_output("ovf16", ovf16, exp_ovf);
            check_output("ovf4", ovf4, exp_ovf);
        end
    end

    task automatic apply_stimulus(input bit te, input bit rw, input logic [4:0] rn,
                                  input logic [31:0] rd, input bit mw, input logic [8:0] ma,
                                  input logic [31:0] md, input bit rdy, input bit clr);
        trace_en      = te;
        reg_write_sig = rw;
        reg_num       = rn;
        reg_data      = rd;
        mem_wr        = mw;
        mem_addr      = ma;
        mem_wr_data   = md;
        m_ready       = rdy;
        clr_drops     = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        cmp_en = 1'b1;

        // Reset mid-stream with five entries queued.
        for (int i = 1; i <= 5; i++)
            apply_stimulus(1, 1, 5'(i), 32'(i * 100), 0, '0, '0, 0, 0);
        check_output("t1_level_before", level16, 5);
        #2 reset = 1'b0;
        #1;
        check_output("t1_level", level16, 0);
        check_output("t1_valid", bus16.m_valid, 0);
        check_output("t1_drop", drop16, 0);
        check_output("t1_ovf", ovf16, 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Single REG event, popped on the following cycle.
        apply_stimulus(1, 1, 5'd5, 32'hDEADBEEF, 0, '0, '0, 1, 0);
        check_output("t2_valid", bus16.m_valid, 1);
        check_output("t2_data", bus16.m_data, {1'b0, 9'd5, 32'hDEADBEEF});
        apply_stimulus(0, 0, '0, '0, 0, '0, '0, 1, 0);
        check_output("t2_valid_after", bus16.m_valid, 0);

        // Filters: x0 write and disabled capture.
        apply_stimulus(1, 1, 5'd0, 32'h1234, 0, '0, '0, 0, 0);
        apply_stimulus(0, 1, 5'd7, 32'h5678, 1, 9'h3, 32'h9, 0, 0);
        check_output("t3_level", level16, 0);
        check_output("t3_drop", drop16, 0);

        // Dual event: REG drains before MEM.
        apply_stimulus(1, 1, 5'd3, 32'd1, 1, 9'h010, 32'hA5A5A5A5, 0, 0);
        check_output("t4_level", level16, 2);
        check_output("t4_head_reg", bus16.m_data, {1'b0, 9'd3, 32'd1});
        apply_stimulus(0, 0, '0, '0, 0, '0, '0, 1, 0);
        check_output("t4_head_mem", bus16.m_data, {1'b1, 9'h010, 32'hA5A5A5A5});
        apply_stimulus(0, 0, '0, '0, 0, '0, '0, 1, 0);
        check_output("t4_empty", level16, 0);

        // Overflow behaviour.
        for (int i = 1; i <= 15; i++)
            apply_stimulus(1, 1, 5'(i), 32'(i), 0, '0, '0, 0, 0);
        check_output("t5_level15", level16, 15);
        apply_stimulus(1, 1, 5'd20, 32'h1, 1, 9'h1FF, 32'h2, 0, 0);
        check_output("t5_level16", level16, 16);
        check_output("t5_drop1", drop16, 1);
        check_output("t5_ovf", ovf16, 1);
        apply_stimulus(1, 1, 5'd21, 32'h3, 1, 9'h0AA, 32'h4, 0, 0);
        check_output("t5_drop3", drop16, 3);
        apply_stimulus(1, 1, 5'd7, 32'h5, 0, '0, '0, 1, 0);
        check_output("t5_pop_level", level16, 15);
        check_output("t5_drop4", drop16, 4);

        // Saturation of the 4-bit counter, then clear beating a drop.
        apply_stimulus(1, 1, 5'd9, 32'h6, 0, '0, '0, 0, 0);
        for (int i = 0; i < 10; i++)
            apply_stimulus(1, 1, 5'd11, 32'(i), 1, 9'(i), 32'(i), 0, 0);
        check_output("t6_sat4", drop4, 4'hF);
        check_output("t6_drop16", drop16, 24);
        apply_stimulus(1, 1, 5'd12, 32'h7, 1, 9'h1, 32'h8, 0, 1);
        check_output("t6_clr16", drop16, 0);
        check_output("t6_clr4", drop4, 0);
        check_output("t6_clr_ovf", ovf4, 0);
        for (int i = 0; i < 18; i++)
            apply_stimulus(0, 0, '0, '0, 0, '0, '0, 1, 0);
        check_output("t6_drained", level16, 0);

        // Mixed traffic across pointer wrap, checked by the model.
        for (int i = 0; i < 80; i++)
            apply_stimulus($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                           5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 1) == 1,
                           9'($urandom_range(0, 511)), $urandom,
                           $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
